// File: rtl/conditional_3d_array_router.sv
// Row-serial frame router: assembles ROWS rows into a buffer, then offers the whole
// frame on the true or false channel. Optional CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN adds cond_err.
module conditional_3d_array_router #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_row [COLS-1:0],
  input  logic                 in_condition,
  output logic                 out_true_valid,
  input  logic                 out_true_ready,
  output logic [BIT_WIDTH-1:0] out_true [ROWS-1:0][COLS-1:0],
  output logic                 out_false_valid,
  input  logic                 out_false_ready,
  output logic [BIT_WIDTH-1:0] out_false [ROWS-1:0][COLS-1:0]
`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
  ,
  output logic                 cond_err
`endif
);

  localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;

  typedef enum logic {FILL, DELIVER} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          row_cnt;
  logic                   sel;
  logic [BIT_WIDTH-1:0]   buffer [ROWS-1:0][COLS-1:0];
  logic                   in_fire;
  logic                   out_fire;
  logic                   last_row;

  assign last_row = (row_cnt == CW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Valids depend on state and sel only, never on the consumer readies.
  always_comb begin
    state_next      = state;
    in_ready        = 1'b0;
    in_fire         = 1'b0;
    out_true_valid  = 1'b0;
    out_false_valid = 1'b0;
    out_fire        = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && last_row) state_next = DELIVER;
      end
      DELIVER: begin
        out_true_valid  = sel;
        out_false_valid = !sel;
        out_fire        = sel ? out_true_ready : out_false_ready;
        if (out_fire) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt <= '0;
      sel     <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          buffer[r][c] <= '0;
        end
      end
    end else if (in_fire) begin
      buffer[row_cnt] <= in_row;
      if (row_cnt == '0) sel <= in_condition;
      if (last_row) row_cnt <= '0;
      else          row_cnt <= row_cnt + 1'b1;
    end
  end

  assign out_true  = buffer;
  assign out_false = buffer;

`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_err <= 1'b0;
    end else if (in_fire && (row_cnt != '0) && (in_condition != sel)) begin
      cond_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conditional_3d_array_router.sv
// Self-checking bench for conditional_3d_array_router (4-bit elements, 8x8 frames):
// table-driven frames plus hand sequences, with a delivery scoreboard.
module tb_conditional_3d_array_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_row [7:0];
  logic       in_condition;
  logic       out_true_valid;
  logic       out_true_ready;
  logic [3:0] out_true [7:0][7:0];
  logic       out_false_valid;
  logic       out_false_ready;
  logic [3:0] out_false [7:0][7:0];
`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
  logic       cond_err;
`endif

  conditional_3d_array_router #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_row          (in_row),
    .in_condition    (in_condition),
    .out_true_valid  (out_true_valid),
    .out_true_ready  (out_true_ready),
    .out_true        (out_true),
    .out_false_valid (out_false_valid),
    .out_false_ready (out_false_ready),
    .out_false       (out_false)
`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
    ,
    .cond_err        (cond_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         cond;
    logic [255:0] data;
  } sb_t;

  typedef struct {
    bit         cond;
    int         base;
    int         mult;
    bit         bubble;
    int         hold;
    logic [3:0] exp35;
  } vec_t;

  sb_t          sb [$];
  int           chk_cnt = 0;
  int           pass_cnt = 0;
  int           cyc = 0;
  int           deliveries = 0;
  int           last_cyc = 0;
  logic [255:0] flat_t, flat_f;
  logic         ht, hf;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    flat_t = '0;
    flat_f = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        flat_t[(r*8+c)*4 +: 4] = out_true[r][c];
        flat_f[(r*8+c)*4 +: 4] = out_false[r][c];
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Every out handshake must match the oldest frame sent.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_true_valid && out_false_valid) check("both_valid", 1, 0);
      ht = out_true_valid && out_true_ready;
      hf = out_false_valid && out_false_ready;
      if (ht || hf) begin
        if (sb.size() == 0) begin
          check("unexpected_delivery", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("deliv_channel", ht, e.cond);
          check("deliv_data", ht ? flat_t : flat_f, e.data);
        end
        deliveries++;
        last_cyc = cyc;
      end
    end
  end

  task automatic send_frame(input bit cond, input int base, input int mult, input int cm,
                            input bit bubble, input int hold, input int nrows, input int flip,
                            output logic [255:0] model);
    sb_t e;
    int  n;
    out_true_ready  = cond ? (hold == 0) : 1'b1;
    out_false_ready = cond ? 1'b1 : (hold == 0);
    model = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        model[(r*8+c)*4 +: 4] = 4'(base + r*mult + c*cm);
    for (int r = 0; r < nrows; r++) begin
      if (bubble) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid     = 1'b1;
      in_condition = (r == flip) ? ~cond : cond;
      for (int c = 0; c < 8; c++) in_row[c] = model[(r*8+c)*4 +: 4];
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
      if (flip < 8) check("cond_err_track", cond_err, (r >= flip) ? 1 : 0);
`endif
    end
    in_valid = 1'b0;
    if (nrows == 8) begin
      e.cond = cond;
      e.data = model;
      sb.push_back(e);
    end
  endtask

  task automatic deliver(input bit cond, input int hold, input logic [3:0] exp35,
                         input logic [255:0] model);
    check("valid_latency", cond ? out_true_valid : out_false_valid, 1);
    check("other_valid_low", cond ? out_false_valid : out_true_valid, 0);
    check("in_ready_low", in_ready, 0);
    check("elem_3_5", cond ? out_true[3][5] : out_false[3][5], exp35);
    check("outputs_agree", flat_t, flat_f);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", cond ? out_true_valid : out_false_valid, 1);
      check("hold_data", cond ? flat_t : flat_f, model);
      check("hold_in_ready", in_ready, 0);
    end
    if (cond) out_true_ready = 1'b1;
    else      out_false_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", cond ? out_true_valid : out_false_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    vec_t         vecs [6];
    logic [255:0] model;
    logic [255:0] all_a;
    int           prev_cyc, d0;

    vecs[0] = '{cond:1, base:0,  mult:1, bubble:0, hold:0, exp35:4'h8};
    vecs[1] = '{cond:0, base:2,  mult:3, bubble:0, hold:5, exp35:4'h0};
    vecs[2] = '{cond:1, base:5,  mult:1, bubble:1, hold:0, exp35:4'hD};
    vecs[3] = '{cond:0, base:7,  mult:2, bubble:1, hold:2, exp35:4'h2};
    vecs[4] = '{cond:1, base:15, mult:0, bubble:0, hold:0, exp35:4'h4};
    vecs[5] = '{cond:0, base:3,  mult:1, bubble:0, hold:0, exp35:4'hB};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_condition = 1'b0;
    out_true_ready = 1'b1;
    out_false_ready = 1'b1;
    for (int c = 0; c < 8; c++) in_row[c] = 4'h0;
    prev_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_true_valid", out_true_valid, 0);
    check("reset_false_valid", out_false_valid, 0);
    check("reset_buffer", flat_t, 256'd0);
`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
    check("reset_cond_err", cond_err, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].cond, vecs[i].base, vecs[i].mult, 1, vecs[i].bubble,
                 vecs[i].hold, 8, 8, model);
      deliver(vecs[i].cond, vecs[i].hold, vecs[i].exp35, model);
      if (i == 5) check("b2b_gap", 32'(last_cyc - prev_cyc), 32'd9);
      prev_cyc = last_cyc;
    end

    // Abort a half-filled frame; only the following frame may be delivered.
    send_frame(1'b1, 9, 1, 1, 1'b0, 0, 4, 8, model);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_valid", out_true_valid | out_false_valid, 0);
    check("midreset_buffer", flat_t, 256'd0);
    d0 = deliveries;
    send_frame(1'b1, 10, 0, 0, 1'b0, 0, 8, 8, all_a);
    deliver(1'b1, 0, 4'hA, all_a);
    check("midreset_one_delivery", deliveries, d0 + 1);
    check("midreset_all_a", flat_t, {64{4'hA}});

`ifdef CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN
    send_frame(1'b1, 1, 1, 1, 1'b0, 0, 8, 5, model);
    deliver(1'b1, 0, 4'h9, model);
    check("cond_err_sticky", cond_err, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("cond_err_reset_clear", cond_err, 0);
`else
    send_frame(1'b0, 4, 1, 2, 1'b0, 0, 8, 3, model);
    deliver(1'b0, 0, 4'h1, model);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/conditional_3d_array_router.md
# conditional_3d_array_router

Registered, row-serial router for 3D arrays (ROWS × COLS elements, each BIT_WIDTH bits): the write-side counterpart of the conditional array select. One frame arrives one row per beat over a valid/ready stream. The block assembles the frame in an internal buffer and delivers it whole on either the "true" or the "false" output channel. The channel is chosen by a condition bit sampled with row 0. It sits between a row-streaming producer and two array consumers, each with its own valid/ready handshake.

## Interface
- `BIT_WIDTH`, default 4: width of one element.
- `ROWS`, default 8: rows per frame; must be ≥ 2.
- `COLS`, default 8: elements per row.

- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: `in_row`/`in_condition` valid.
- `in_ready`, output, 1: block accepts a row this cycle.
- `in_row`, input, [BIT_WIDTH-1:0] × [COLS-1:0] (unpacked): one row; `in_row[c]` is column c.
- `in_condition`, input, 1: route select; sampled only on the row-0 beat. 1 selects true, 0 selects false.
- `out_true_valid`, output, 1: complete frame available on the true channel.
- `out_true_ready`, input, 1: true consumer accepts.
- `out_true`, output, [BIT_WIDTH-1:0] × [ROWS-1:0][COLS-1:0] (unpacked): buffer contents.
- `out_false_valid`, output, 1: complete frame available on the false channel.
- `out_false_ready`, input, 1: false consumer accepts.
- `out_false`, output, [BIT_WIDTH-1:0] × [ROWS-1:0][COLS-1:0] (unpacked): buffer contents; same data as `out_true`.
- `cond_err`, output, 1: present only with `CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN`.

## Operation
- **State:** 2-state FSM, FILL and DELIVER.
- **Registers:**
  - `row_cnt`: $clog2(ROWS) bits, or 1 bit if ROWS=2.
  - `sel`: latched condition.
  - `buffer`: ROWS×COLS×BIT_WIDTH bits.
- **FILL:**
  - `in_ready`=1.
  - On an in handshake (`in_valid`&&`in_ready`), `in_row` is written to `buffer[row_cnt]`.
  - If `row_cnt`==0, `sel` <= `in_condition`.
  - If `row_cnt`==ROWS-1: `row_cnt` <= 0 and the state goes to DELIVER. Otherwise `row_cnt` increments.
  - No handshake means no state change.
- **DELIVER:**
  - `in_ready`=0.
  - `out_true_valid`=`sel`; `out_false_valid`=!`sel`.
  - Only the ready of the selected channel matters; the unselected ready is ignored.
  - On the selected handshake, the state goes to FILL.
- **Data outputs:** both array outputs continuously reflect `buffer`. They are undefined for use unless the matching valid is high. The buffer is not modified in DELIVER.
- **Row order:** row r of a frame is the (r+1)-th accepted beat, so `out_*[r][c]` = `in_row[c]` of beat r.
- **Reset:** (`rst_n`=0 at a rising edge) gives state FILL, `row_cnt`=0, `sel`=0, `buffer` all zeros, `cond_err`=0. Both out valids are 0 after reset.
- **Reset mid-frame or mid-DELIVER:** the partial or undelivered frame is discarded. No output valid appears for it.
- **Ready/valid rules:**
  - Valids never depend combinationally on `out_*_ready`.
  - `in_ready` is a function of state only.
  - Once asserted, an out valid stays high with stable data until its handshake.

## Timing
- **Latency:** the selected valid rises in the cycle after the edge that accepts row ROWS-1.
- **Deliver-to-fill:** `in_ready` returns high in the cycle after the edge that completes the out handshake.
- **Throughput:** minimum ROWS+1 cycles per frame (ROWS fill beats plus 1 deliver beat with ready held high).
- **No overlap:** input rows are not accepted during DELIVER.
- **Back-pressure:** in_valid gaps stall FILL indefinitely with no data loss.

## Configuration
- **Macro:** `CONDITIONAL_ARRAY_ROUTER_COND_CHECK_EN`.
- **Defined:**
  - Port `cond_err` exists.
  - `cond_err` is sticky and set at the edge accepting any row r>0 whose `in_condition` differs from the `sel` latched at row 0.
  - It is cleared only by reset.
  - Routing still follows `sel`.
- **Undefined:** the port and its logic are absent. `in_condition` is ignored on rows r>0.

## Test plan
All with BIT_WIDTH=4, ROWS=8, COLS=8.
- **Single true frame:**
  - Stimulus: reset, then 8 back-to-back beats with `in_row[c]`=(r+c)&4'hF and `in_condition`=1 on row 0, `out_true_ready`=1.
  - Required: `out_true_valid` high exactly 1 cycle, in cycle 9 after the first beat; `out_true[3][5]`=4'h8; `out_false_valid` never high; `in_ready` low that cycle only.
- **False routing with back-pressure:**
  - Stimulus: `in_condition`=0 at row 0; `out_false_ready` held low 5 cycles after valid, while `out_true_ready`=1 throughout.
  - Required: `out_false_valid` held 6 cycles with stable data; `in_ready`=0 throughout; no delivery on the true channel.
- **Input bubbles:** in_valid toggled 1/0 every cycle across a frame -> frame assembled correctly; valid after the 8th accepted beat.
- **Reset mid-frame:**
  - Stimulus: rst_n low for 1 cycle after 4 rows, then a full new frame of all-4'hA.
  - Required: only one delivery, every element 4'hA.
- **Back-to-back frames:**
  - Stimulus: two frames with conditions 1 then 0, all readies high.
  - Required: true delivery, then false delivery 9 cycles later; second frame data correct.
- **`COND_CHECK_EN` built:**
  - Stimulus: `in_condition`=1 on row 0 and 0 on row 5.
  - Required: `cond_err` rises the cycle after row 5 is accepted and stays high; the frame is still delivered on the true channel.
